io_channel_sequencer: RTL and testbench

Parametrised successor to the single-operation IO block. It runs CHANNELS independent timed pulse channels concurrently on an OUTPUTS-wide pin vector. It also handles immediate pin writes, per-pin and global cancels, and delayed snapshot reads of INPUTS. It sits between the instruction decoder and the board IO pins, with a valid/ready command port and a single-cycle status response per command.

---
 rtl/io_channel_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_io_channel_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_channel_sequencer.sv
// rtl/io_channel_sequencer.sv - Concurrent timed pulse channels, pin writes, cancels and delayed input reads
// Optional INPUT_SYNC_EN: READ snapshots input_io through a 2-flop synchroniser.
module io_channel_sequencer #(
    parameter int                     OUTPUTS          = 32,
    parameter int                     INPUTS           = 32,
    parameter int                     CHANNELS         = 4,
    parameter int                     TIMER_WIDTH      = 44,
    parameter int                     IDX_WIDTH        = 5,
    parameter logic [TIMER_WIDTH-1:0] ONE_SECOND_CLOCK = 44'h00005F5E100
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [IDX_WIDTH-1:0]   cmd_pin,
    input  logic [TIMER_WIDTH-1:0] cmd_time,
    input  logic                   cmd_value,
    output logic                   rsp_valid,
    output logic [1:0]             rsp_status,
    output logic [INPUTS-1:0]      rsp_data,
    input  logic [INPUTS-1:0]      input_io,
    output logic [OUTPUTS-1:0]     output_io,
    output logic                   busy
);

    localparam logic [2:0] OP_PULSE      = 3'b000;
    localparam logic [2:0] OP_DPULSE     = 3'b001;
    localparam logic [2:0] OP_SET        = 3'b010;
    localparam logic [2:0] OP_READ       = 3'b011;
    localparam logic [2:0] OP_CANCEL     = 3'b100;
    localparam logic [2:0] OP_CANCEL_ALL = 3'b101;

    localparam logic [1:0] ST_OK         = 2'b00;
    localparam logic [1:0] ST_NO_CHANNEL = 2'b01;
    localparam logic [1:0] ST_CONFLICT   = 2'b10;
    localparam logic [1:0] ST_ILLEGAL    = 2'b11;

    localparam logic [TIMER_WIDTH-1:0] T_ONE = TIMER_WIDTH'(1);

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_DELAY = 2'd1,
        CH_HIGH  = 2'd2
    } ch_state_t;

    ch_state_t              ch_state [CHANNELS];
    logic [IDX_WIDTH-1:0]   ch_pin   [CHANNELS];
    logic [TIMER_WIDTH-1:0] ch_cnt   [CHANNELS];
    logic [TIMER_WIDTH-1:0] ch_len   [CHANNELS];

    logic                   read_pending;
    logic [TIMER_WIDTH-1:0] read_cnt;
    logic                   pend_valid;
    logic [1:0]             pend_status;
    logic [INPUTS-1:0]      read_src;

    logic                   accept;
    logic                   pin_ok;
    logic                   owned;
    logic                   free_found;
    logic [TIMER_WIDTH-1:0] eff_time;
    logic [OUTPUTS-1:0]     cmd_mask;
    logic [OUTPUTS-1:0]     out_next;
    logic [OUTPUTS-1:0]     ch_mask  [CHANNELS];
    logic [CHANNELS-1:0]    ch_active;
    logic [CHANNELS-1:0]    ch_last;
    logic [CHANNELS-1:0]    alloc_sel;
    logic [CHANNELS-1:0]    cancel_hit;
    logic                   do_pulse;
    logic                   do_dpulse;
    logic                   do_set;
    logic                   do_read;
    logic                   do_cancel;
    logic                   do_cancel_all;
    logic [1:0]             cmd_status;

    assign cmd_ready = !read_pending;
    assign accept    = cmd_valid && cmd_ready;
    assign eff_time  = (cmd_time == '0) ? T_ONE : cmd_time;
    assign pin_ok    = (32'(cmd_pin) < 32'(OUTPUTS));
    assign busy      = read_pending || (|ch_active);

`ifdef INPUT_SYNC_EN
    logic [INPUTS-1:0] sync_q1;
    logic [INPUTS-1:0] sync_q2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= input_io;
            sync_q2 <= sync_q1;
        end
    end

    assign read_src = sync_q2;
`else
    assign read_src = input_io;
`endif

    // One-hot pin masks avoid indexing output_io with an index wider than the vector.
    always_comb begin
        cmd_mask = '0;
        for (int p = 0; p < OUTPUTS; p++) begin
            cmd_mask[p] = (32'(cmd_pin) == 32'(p));
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            ch_mask[c] = '0;
            for (int p = 0; p < OUTPUTS; p++) begin
                ch_mask[c][p] = (32'(ch_pin[c]) == 32'(p));
            end
        end
    end

    // Ownership and allocation look only at registered channel state, so a
    // channel expiring on this edge is still treated as busy.
    always_comb begin
        owned      = 1'b0;
        free_found = 1'b0;
        alloc_sel  = '0;
        ch_active  = '0;
        ch_last    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ch_active[c] = (ch_state[c] != CH_IDLE);
            ch_last[c]   = (ch_cnt[c] <= T_ONE);
            if (ch_active[c] && (ch_pin[c] == cmd_pin)) begin
                owned = 1'b1;
            end
            if (!ch_active[c] && !free_found) begin
                alloc_sel[c] = 1'b1;
                free_found   = 1'b1;
            end
        end
    end

    always_comb begin
        cmd_status    = ST_OK;
        do_pulse      = 1'b0;
        do_dpulse     = 1'b0;
        do_set        = 1'b0;
        do_read       = 1'b0;
        do_cancel     = 1'b0;
        do_cancel_all = 1'b0;
        if (accept) begin
            case (cmd_op)
                OP_PULSE, OP_DPULSE: begin
                    if (!pin_ok) begin
                        cmd_status = ST_ILLEGAL;
                    end else if (owned) begin
                        cmd_status = ST_CONFLICT;
                    end else if (!free_found) begin
                        cmd_status = ST_NO_CHANNEL;
                    end else if (cmd_op == OP_PULSE) begin
                        do_pulse = 1'b1;
                    end else begin
                        do_dpulse = 1'b1;
                    end
                end
                OP_SET: begin
                    if (!pin_ok) begin
                        cmd_status = ST_ILLEGAL;
                    end else if (owned) begin
                        cmd_status = ST_CONFLICT;
                    end else begin
                        do_set = 1'b1;
                    end
                end
                OP_READ: begin
                    do_read = 1'b1;
                end
                OP_CANCEL: begin
                    if (!pin_ok) begin
                        cmd_status = ST_ILLEGAL;
                    end else begin
                        do_cancel = 1'b1;
                    end
                end
                OP_CANCEL_ALL: begin
                    do_cancel_all = 1'b1;
                end
                default: begin
                    cmd_status = ST_ILLEGAL;
                end
            endcase
        end
    end

    always_comb begin
        cancel_hit = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            cancel_hit[c] = ch_active[c] &&
                            (do_cancel_all || (do_cancel && (ch_pin[c] == cmd_pin)));
        end
    end

    // Later writes win: channel rise, then channel expiry, then the accepted command.
    always_comb begin
        out_next = output_io;
        for (int c = 0; c < CHANNELS; c++) begin
            if ((ch_state[c] == CH_DELAY) && ch_last[c]) begin
                out_next = out_next | ch_mask[c];
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if ((ch_state[c] == CH_HIGH) && ch_last[c]) begin
                out_next = out_next & ~ch_mask[c];
            end
        end
        if (do_set) begin
            out_next = cmd_value ? (out_next | cmd_mask) : (out_next & ~cmd_mask);
        end
        if (do_cancel) begin
            out_next = out_next & ~cmd_mask;
        end
        if (do_cancel_all) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (ch_active[c]) begin
                    out_next = out_next & ~ch_mask[c];
                end
            end
        end
        if (do_pulse) begin
            out_next = out_next | cmd_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            output_io    <= '0;
            rsp_valid    <= 1'b0;
            rsp_status   <= ST_OK;
            rsp_data     <= '0;
            read_pending <= 1'b0;
            read_cnt     <= '0;
            pend_valid   <= 1'b0;
            pend_status  <= ST_OK;
            for (int c = 0; c < CHANNELS; c++) begin
                ch_state[c] <= CH_IDLE;
                ch_pin[c]   <= '0;
                ch_cnt[c]   <= '0;
                ch_len[c]   <= '0;
            end
        end else begin
            output_io   <= out_next;
            pend_valid  <= accept && (cmd_op != OP_READ);
            pend_status <= cmd_status;

            // A read can never complete on the same edge as a non-read response:
            // no command is accepted while the read is outstanding.
            if (read_pending && (read_cnt <= T_ONE)) begin
                rsp_valid  <= 1'b1;
                rsp_status <= ST_OK;
                rsp_data   <= read_src;
            end else begin
                rsp_valid  <= pend_valid;
                rsp_status <= pend_valid ? pend_status : ST_OK;
                rsp_data   <= '0;
            end

            if (do_read) begin
                read_pending <= 1'b1;
                read_cnt     <= eff_time;
            end else if (read_pending) begin
                if (read_cnt <= T_ONE) begin
                    read_pending <= 1'b0;
                    read_cnt     <= '0;
                end else begin
                    read_cnt <= read_cnt - T_ONE;
                end
            end

            for (int c = 0; c < CHANNELS; c++) begin
                if (cancel_hit[c]) begin
                    ch_state[c] <= CH_IDLE;
                    ch_cnt[c]   <= '0;
                end else if (alloc_sel[c] && (do_pulse || do_dpulse)) begin
                    ch_pin[c] <= cmd_pin;
                    ch_len[c] <= eff_time;
                    if (do_pulse) begin
                        ch_state[c] <= CH_HIGH;
                        ch_cnt[c]   <= eff_time;
                    end else begin
                        ch_state[c] <= CH_DELAY;
                        ch_cnt[c]   <= ONE_SECOND_CLOCK;
                    end
                end else begin
                    case (ch_state[c])
                        CH_DELAY: begin
                            if (ch_last[c]) begin
                                ch_state[c] <= CH_HIGH;
                                ch_cnt[c]   <= ch_len[c];
                            end else begin
                                ch_cnt[c] <= ch_cnt[c] - T_ONE;
                            end
                        end
                        CH_HIGH: begin
                            if (ch_last[c]) begin
                                ch_state[c] <= CH_IDLE;
                                ch_cnt[c]   <= '0;
                            end else begin
                                ch_cnt[c] <= ch_cnt[c] - T_ONE;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_io_channel_sequencer.sv
// tb/tb_io_channel_sequencer.sv - Directed and random stimulus against an edge-scheduled reference model
module tb_io_channel_sequencer;

    localparam int NOUT = 32;
    localparam int NIN  = 32;
    localparam int NCH  = 4;
    localparam int TW   = 44;
    localparam int IW   = 6;
    localparam longint OSC = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [IW-1:0] cmd_pin = '0;
    logic [TW-1:0] cmd_time = '0;
    logic          cmd_value = 1'b0;
    logic          rsp_valid;
    logic [1:0]    rsp_status;
    logic [NIN-1:0] rsp_data;
    logic [NIN-1:0] input_io = '0;
    logic [NOUT-1:0] output_io;
    logic          busy;

    io_channel_sequencer #(
        .OUTPUTS(NOUT), .INPUTS(NIN), .CHANNELS(NCH), .TIMER_WIDTH(TW),
        .IDX_WIDTH(IW), .ONE_SECOND_CLOCK(44'd10)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_pin(cmd_pin), .cmd_time(cmd_time), .cmd_value(cmd_value),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_data(rsp_data),
        .input_io(input_io), .output_io(output_io), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each channel is a reservation with absolute rise/fall edges.
    longint     e_now = 0;
    bit [31:0]  m_out;
    bit         ch_act  [NCH];
    int         ch_pin  [NCH];
    longint     ch_rise [NCH];
    longint     ch_fall [NCH];
    bit         rd_pend;
    longint     rd_due;
    longint     nr_due;
    logic [1:0] nr_st;
    bit [31:0]  s1, s2;
    bit         exp_rv;
    logic [1:0] exp_st;
    bit [31:0]  exp_data;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e_now);
        end
    endtask

    function automatic bit ch_busy(int c);
        return ch_act[c] && (ch_fall[c] >= e_now);
    endfunction

    function automatic bit m_busy();
        bit b = rd_pend;
        for (int c = 0; c < NCH; c++) begin
            if (ch_act[c] && (ch_fall[c] > e_now)) b = 1'b1;
        end
        return b;
    endfunction

    task automatic model_reset();
        m_out = '0; rd_pend = 1'b0; rd_due = -1; nr_due = -1; nr_st = 2'b00;
        s1 = '0; s2 = '0;
        for (int c = 0; c < NCH; c++) begin
            ch_act[c] = 1'b0; ch_pin[c] = 0; ch_rise[c] = -1; ch_fall[c] = -1;
        end
    endtask

    task automatic model_edge();
        bit ready_before;
        bit [31:0] snap;
        int pin;
        longint n;
        int sel;
        bit owned;
        logic [1:0] st;
        e_now++;
        ready_before = !rd_pend;
`ifdef INPUT_SYNC_EN
        snap = s2; s2 = s1; s1 = input_io;
`else
        snap = input_io;
`endif
        for (int c = 0; c < NCH; c++) begin
            if (ch_act[c] && ch_rise[c] == e_now) m_out[ch_pin[c]] = 1'b1;
        end
        for (int c = 0; c < NCH; c++) begin
            if (ch_act[c] && ch_fall[c] == e_now) m_out[ch_pin[c]] = 1'b0;
        end
        exp_rv = 1'b0; exp_st = 2'b00; exp_data = '0;
        if (nr_due == e_now) begin
            exp_rv = 1'b1; exp_st = nr_st;
        end
        if (rd_pend && rd_due == e_now) begin
            exp_rv = 1'b1; exp_st = 2'b00; exp_data = snap; rd_pend = 1'b0;
        end
        if (cmd_valid && ready_before) begin
            pin = int'(cmd_pin);
            n = (cmd_time == 0) ? 1 : longint'(cmd_time);
            owned = 1'b0; sel = -1; st = 2'b00;
            for (int c = 0; c < NCH; c++) begin
                if (ch_busy(c)) begin
                    if (ch_pin[c] == pin) owned = 1'b1;
                end else if (sel < 0) begin
                    sel = c;
                end
            end
            case (cmd_op)
                3'b000, 3'b001: begin
                    if (pin >= NOUT) st = 2'b11;
                    else if (owned) st = 2'b10;
                    else if (sel < 0) st = 2'b01;
                    else begin
                        ch_act[sel] = 1'b1; ch_pin[sel] = pin;
                        if (cmd_op == 3'b000) begin
                            ch_rise[sel] = e_now; ch_fall[sel] = e_now + n; m_out[pin] = 1'b1;
                        end else begin
                            ch_rise[sel] = e_now + OSC; ch_fall[sel] = e_now + OSC + n;
                        end
                    end
                end
                3'b010: begin
                    if (pin >= NOUT) st = 2'b11;
                    else if (owned) st = 2'b10;
                    else m_out[pin] = cmd_value;
                end
                3'b011: begin
                    rd_pend = 1'b1; rd_due = e_now + n;
                end
                3'b100: begin
                    if (pin >= NOUT) st = 2'b11;
                    else begin
                        for (int c = 0; c < NCH; c++) begin
                            if (ch_busy(c) && ch_pin[c] == pin) ch_act[c] = 1'b0;
                        end
                        m_out[pin] = 1'b0;
                    end
                end
                3'b101: begin
                    for (int c = 0; c < NCH; c++) begin
                        if (ch_busy(c)) begin
                            m_out[ch_pin[c]] = 1'b0; ch_act[c] = 1'b0;
                        end
                    end
                end
                default: st = 2'b11;
            endcase
            if (cmd_op != 3'b011) begin
                nr_due = e_now + 1; nr_st = st;
            end
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input bit v, input logic [2:0] op, input int pin,
                        input longint t, input bit val);
        cmd_valid = v; cmd_op = op; cmd_pin = IW'(pin); cmd_time = TW'(t); cmd_value = val;
        check_eq("cmd_ready", {63'd0, cmd_ready}, {63'd0, !rd_pend});
        @(posedge clk);
        model_edge();
        #1;
        check_eq("output_io", {32'd0, output_io}, {32'd0, m_out});
        check_eq("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_rv});
        if (exp_rv) begin
            check_eq("rsp_status", {62'd0, rsp_status}, {62'd0, exp_st});
            check_eq("rsp_data", {32'd0, rsp_data}, {32'd0, exp_data});
        end
        check_eq("busy", {63'd0, busy}, {63'd0, m_busy()});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'b000, 0, 0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0; cmd_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        check_eq("reset output_io", {32'd0, output_io}, 64'd0);
        check_eq("reset busy", {63'd0, busy}, 64'd0);
        check_eq("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int r;
        logic [2:0] op;
        model_reset();
        @(negedge clk);
        do_reset(2);

        step(1'b1, 3'b000, 3, 5, 1'b0);
        idle(7);
        step(1'b1, 3'b000, 2, 30, 1'b0);
        idle(3);
        do_reset(2);
        idle(2);

        for (int p = 0; p < 4; p++) step(1'b1, 3'b000, p, 20, 1'b0);
        step(1'b1, 3'b000, 4, 20, 1'b0);
        idle(16);
        step(1'b1, 3'b000, 4, 20, 1'b0);
        idle(25);

        step(1'b1, 3'b001, 7, 3, 1'b0);
        idle(15);

        step(1'b1, 3'b000, 5, 50, 1'b0);
        step(1'b1, 3'b010, 5, 0, 1'b1);
        idle(8);
        step(1'b1, 3'b100, 5, 0, 1'b0);
        step(1'b1, 3'b010, 5, 0, 1'b1);
        idle(2);

        input_io = 32'hA5A5_0F0F;
        step(1'b1, 3'b011, 0, 4, 1'b0);
        idle(2);
        input_io = 32'h1234_5678;
        idle(4);

        step(1'b1, 3'b110, 1, 3, 1'b0);
        step(1'b1, 3'b000, 40, 3, 1'b0);
        step(1'b1, 3'b000, 9, 0, 1'b0);
        idle(3);

        step(1'b1, 3'b000, 6, 64'h800_0000_0005, 1'b0);
        step(1'b1, 3'b001, 8, 2, 1'b0);
        step(1'b1, 3'b010, 10, 0, 1'b1);
        idle(3);
        step(1'b1, 3'b101, 0, 0, 1'b0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset(2);
            r = $urandom_range(0, 99);
            if (r < 25) op = 3'b000;
            else if (r < 35) op = 3'b001;
            else if (r < 50) op = 3'b010;
            else if (r < 58) op = 3'b011;
            else if (r < 72) op = 3'b100;
            else if (r < 75) op = 3'b101;
            else if (r < 78) op = 3'(6 + $urandom_range(0, 1));
            else op = 3'b000;
            input_io = $urandom;
            step(r < 78, op,
                 ($urandom_range(0, 15) == 0) ? int'($urandom_range(32, 63)) : int'($urandom_range(0, 7)),
                 longint'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
